// File: rtl/sma_rr_pkg.sv
// Shared defaults and types for the time-multiplexed moving-average scheduler.
package sma_rr_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 16;
  localparam int CHAN_W       = $clog2(DEF_CHANNELS);

  typedef logic signed [DEF_WIDTH-1:0] sample_t;
  typedef logic [CHAN_W-1:0]           chan_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins. Grant is one-hot and suppressed when enable is low;
// idx/any report the winner regardless of enable.
module rr_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]         req,
  input  logic                        enable,
  input  logic [$clog2(CHANNELS)-1:0] ptr,
  output logic [CHANNELS-1:0]         grant,
  output logic [$clog2(CHANNELS)-1:0] idx,
  output logic                        any
);

  localparam int CW = $clog2(CHANNELS);

  int unsigned cand;

  // Scan CHANNELS positions starting at ptr; keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = (32'(ptr) + k) % CHANNELS;
      if (!any && req[CW'(cand)]) begin
        any = 1'b1;
        idx = CW'(cand);
      end
    end
    if (enable && any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sma_rr_scheduler.sv
// Shared 4-tap moving-average engine. One channel per cycle is granted by a
// round-robin arbiter; its sample plus its private 3-deep history feed a
// single adder, and the sum lands in a back-pressured output register.
module sma_rr_scheduler
  import sma_rr_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         x_valid,
  input  logic [CHANNELS*WIDTH-1:0]   x_data,
  output logic [CHANNELS-1:0]         x_ready,
  input  logic                        flush,
  output logic                        y_valid,
  output logic [WIDTH-1:0]            y_data,
  output logic [$clog2(CHANNELS)-1:0] y_chan,
  input  logic                        y_ready
);

  localparam int CW = $clog2(CHANNELS);

  logic [CW-1:0]       ptr;
  logic [CW-1:0]       ptr_next;
  logic [CW-1:0]       gidx;
  logic [CHANNELS-1:0] grant;
  logic                any_req;
  logic                can_accept;
  logic                accept;

  logic signed [WIDTH-1:0] h1 [CHANNELS];
  logic signed [WIDTH-1:0] h2 [CHANNELS];
  logic signed [WIDTH-1:0] h3 [CHANNELS];

  logic signed [WIDTH-1:0] x_sel;
  logic signed [WIDTH-1:0] h1_sel;
  logic signed [WIDTH-1:0] h2_sel;
  logic signed [WIDTH-1:0] h3_sel;
  logic signed [WIDTH-1:0] sum_lo;
  logic signed [WIDTH-1:0] sum_hi;
  logic signed [WIDTH-1:0] sum;

  // Output slot is usable when empty or being drained this cycle.
  assign can_accept = !y_valid || y_ready;

  rr_arbiter #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .req   (x_valid),
    .enable(can_accept && !rst),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_req)
  );

  assign x_ready = grant;
  assign accept  = any_req && can_accept;

  // Operand select for the granted channel; flush zeroes the history taps
  // so a sample accepted alongside flush sums against an empty history.
  always_comb begin
    x_sel  = x_data[int'(gidx)*WIDTH +: WIDTH];
    h1_sel = '0;
    h2_sel = '0;
    h3_sel = '0;
    if (!flush) begin
      h1_sel = h1[gidx];
      h2_sel = h2[gidx];
      h3_sel = h3[gidx];
    end
  end

  // Shared adder tree, wrapping at WIDTH bits.
  always_comb begin
    sum_lo = x_sel + h1_sel;
    sum_hi = h2_sel + h3_sel;
    sum    = sum_lo + sum_hi;
  end

  // Pointer advances to the slot after the winner, wrapping at CHANNELS.
  always_comb begin
    ptr_next = gidx + 1'b1;
    if (gidx == CW'(CHANNELS - 1)) begin
      ptr_next = '0;
    end
  end

  // Round-robin pointer: moves only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // History bank: granted channel shifts in its sample; flush clears the
  // rest. With flush and accept together, the granted channel keeps only x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
        h3[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (accept && (gidx == CW'(i))) begin
          h1[i] <= x_sel;
          h2[i] <= h1_sel;
          h3[i] <= h2_sel;
        end else if (flush) begin
          h1[i] <= '0;
          h2[i] <= '0;
          h3[i] <= '0;
        end
      end
    end
  end

  // Output register: load on accept, drop valid when drained, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_chan  <= '0;
    end else if (accept) begin
      y_valid <= 1'b1;
      y_data  <= sum;
      y_chan  <= gidx;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sma_rr_scheduler.sv
// Self-checking bench for sma_rr_scheduler: directed scenarios plus random
// traffic, all compared against a queue-based behavioural model.
module tb_sma_rr_scheduler;
  import sma_rr_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   x_valid;
  logic [N*W-1:0] x_data;
  logic [N-1:0]   x_ready;
  logic           flush;
  logic           y_valid;
  logic [W-1:0]   y_data;
  logic [1:0]     y_chan;
  logic           y_ready;

  int checks = 0;
  int errors = 0;

  // Model state: last three accepted samples per channel, newest first.
  int hq [N][$];
  int mptr;
  int mvalid;
  int mdata;
  int mchan;

  logic [N-1:0] pend;

  sma_rr_scheduler #(
    .CHANNELS(N),
    .WIDTH   (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .x_valid(x_valid),
    .x_data (x_data),
    .x_ready(x_ready),
    .flush  (flush),
    .y_valid(y_valid),
    .y_data (y_data),
    .y_chan (y_chan),
    .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap16(input int v);
    sample_t t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int sample_of(input int c);
    sample_t t;
    t = x_data[c*W +: W];
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) hq[c].delete();
    mptr   = 0;
    mvalid = 0;
    mdata  = 0;
    mchan  = 0;
  endtask

  // One clock cycle: entered just after a negedge with inputs driven.
  // Checks outputs and grant, then advances the model at the posedge.
  task automatic step(output logic [N-1:0] gv);
    int g;
    int s;
    bit can;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && x_valid[(mptr + k) % N]) g = (mptr + k) % N;
    end
    can = (mvalid == 0) || y_ready;
    gv  = '0;
    if (g >= 0 && can && !rst) gv[g] = 1'b1;
    check("x_ready", int'(x_ready), int'(gv));
    check("y_valid", int'(y_valid), mvalid);
    check("y_data",  int'($signed(y_data)), mdata);
    check("y_chan",  int'(y_chan), mchan);
    @(posedge clk);
    if (!rst) begin
      if (gv != '0) begin
        s = sample_of(g);
        if (flush) for (int c = 0; c < N; c++) hq[c].delete();
        foreach (hq[g][j]) s += hq[g][j];
        mdata  = wrap16(s);
        mchan  = g;
        mvalid = 1;
        hq[g].push_front(sample_of(g));
        if (hq[g].size() > 3) void'(hq[g].pop_back());
        mptr = (g + 1) % N;
      end else begin
        if (mvalid != 0 && y_ready) mvalid = 0;
        if (flush) for (int c = 0; c < N; c++) hq[c].delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic set_x(input int c, input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    x_data[c*W +: W] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x_valid = '0;
    flush = 1'b0;
    y_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [N-1:0] gv;

  initial begin
    rst     = 1'b1;
    x_valid = '1;
    x_data  = '0;
    flush   = 1'b0;
    y_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset state, including grant suppression while rst is high.
    check("rst_x_ready", int'(x_ready), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_y_data",  int'(y_data), 0);
    check("rst_y_chan",  int'(y_chan), 0);
    rst = 1'b0;
    x_valid = '0;

    // Single channel, running sums 1,3,6,10,14.
    for (int i = 1; i <= 5; i++) begin
      x_valid = 4'b0001;
      set_x(0, i);
      step(gv);
    end
    x_valid = '0;
    check("single_last", int'($signed(y_data)), 14);
    step(gv);

    // All channels, constant 100*(i+1); channel 2's fourth result is 1200.
    do_reset();
    for (int c = 0; c < N; c++) set_x(c, 100 * (c + 1));
    x_valid = '1;
    for (int i = 0; i < 15; i++) step(gv);
    check("rr4_chan", int'(y_chan), 2);
    check("rr4_data", int'($signed(y_data)), 1200);
    step(gv);
    x_valid = '0;
    step(gv);

    // Two's-complement wrap: 4 x 16000 = 64000 -> -1536.
    do_reset();
    set_x(1, 16000);
    for (int i = 0; i < 4; i++) begin
      x_valid = 4'b0010;
      step(gv);
    end
    x_valid = '0;
    check("wrap", int'($signed(y_data)), -1536);
    step(gv);

    // Back-pressure: result pending, consumer stalls 3 cycles.
    do_reset();
    x_valid = 4'b0001;
    set_x(0, 11);
    step(gv);
    y_ready = 1'b0;
    x_valid = 4'b0110;
    set_x(1, 22);
    set_x(2, 33);
    for (int i = 0; i < 3; i++) step(gv);
    check("bp_hold", int'($signed(y_data)), 11);
    y_ready = 1'b1;
    #1;
    check("bp_release_grant", int'(x_ready), 2);
    step(gv);
    x_valid = '0;
    step(gv);
    step(gv);

    // Flush alongside accept: history {5,5,5} discarded, then 7, then 7+1.
    do_reset();
    set_x(0, 5);
    for (int i = 0; i < 3; i++) begin
      x_valid = 4'b0001;
      step(gv);
    end
    flush = 1'b1;
    set_x(0, 7);
    step(gv);
    check("flush_sum", int'($signed(y_data)), 7);
    flush = 1'b0;
    set_x(0, 1);
    step(gv);
    check("post_flush", int'($signed(y_data)), 8);
    x_valid = '0;
    step(gv);

    // Async reset between edges mid-burst.
    x_valid = '1;
    for (int c = 0; c < N; c++) set_x(c, 40 + c);
    step(gv);
    step(gv);
    #2;
    rst = 1'b1;
    #1;
    check("async_y_valid", int'(y_valid), 0);
    check("async_x_ready", int'(x_ready), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    x_valid = 4'b1000;
    set_x(3, 9);
    step(gv);
    check("post_rst_data", int'($signed(y_data)), 9);
    check("post_rst_chan", int'(y_chan), 3);
    x_valid = '0;
    step(gv);

    // Random traffic; a stalled request keeps its data stable.
    do_reset();
    pend = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!pend[c]) begin
          x_valid[c] = ($urandom_range(0, 9) < 6);
          set_x(c, int'($urandom_range(0, 65535)));
        end
      end
      y_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 49) == 0);
      step(gv);
      pend = x_valid & ~gv;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sma_rr_scheduler.md
# sma_rr_scheduler

Time-multiplexed 4-tap simple-moving-average engine shared among several sample streams. A round-robin scheduler grants one requesting channel per cycle. The block keeps a private 3-deep sample history per channel and drives one shared 4-input adder. The result is issued through a single registered, back-pressured output port tagged with the channel index. It sits between per-channel sample sources and a downstream consumer, replacing one filter instance per channel.

## Interface
- CHANNELS, 4, number of requesting streams (2..16)
- WIDTH, 16, signed sample and result width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- x_valid  in  CHANNELS  per-channel sample request
- x_data  in  CHANNELS*WIDTH  signed samples; channel i at bits [i*WIDTH +: WIDTH]
- x_ready  out  CHANNELS  one-hot grant; sample i accepted when x_valid[i] && x_ready[i]
- flush  in  1  synchronous clear of all channel histories
- y_valid  out  1  output register holds a result
- y_data  out  WIDTH  signed 4-tap sum
- y_chan  out  clog2(CHANNELS)  channel that produced y_data
- y_ready  in  1  consumer accepts result when y_valid && y_ready

## Operation
- Per channel i, the history registers are h1[i], h2[i] and h3[i]. All three reset to 0.
- can_accept = !y_valid || y_ready. The output slot is free or being drained this cycle.
- Arbitration, combinational:
  - Search order is ptr, ptr+1, …, wrapping modulo CHANNELS.
  - The first i with x_valid[i] is granted. x_ready[i] = 1 only if can_accept.
  - At most one x_ready bit is high. When can_accept = 0, x_ready = 0.
- On accept of channel g:
  - The sum is x + h1[g] + h2[g] + h3[g], truncated to WIDTH bits, two's-complement wrap. No saturation.
  - The sum is written to y_data, g is written to y_chan, and y_valid is set to 1.
  - The history shifts: h3←h2, h2←h1, h1←x. Only channel g shifts; other channels hold.
  - The pointer updates: ptr ← (g+1) mod CHANNELS.
- No accept while y_valid && y_ready: y_valid ← 0. y_data and y_chan hold their last value.
- No accept while y_valid && !y_ready: all outputs hold. ptr holds.
- No valid requests: ptr holds.
- flush:
  - Clears every h* to 0 in the same edge.
  - If a sample is accepted in the same cycle, its sum uses zero history, so y_data = x. Afterwards h1[g] = x and h2, h3 = 0.
  - flush does not affect y_valid, y_data, y_chan or ptr.
- A source must hold x_data[i] stable while x_valid[i] && !x_ready[i]. The block does not check this.

## Timing
- Latency: a sample accepted at edge t appears as y_valid/y_data at the output after edge t. There is one register stage.
- Throughput: one result per cycle when y_ready is held high. x_ready is combinational from x_valid, ptr, y_valid and y_ready. There is no combinational path from x_data to any output.
- Starvation bound: a channel holding x_valid is granted within CHANNELS accept cycles.
- Reset values: y_valid=0, y_data=0, y_chan=0, ptr=0, all history 0. x_ready=0 while rst is high.
- Reset asserted mid-stream: any pending result is discarded and all history is lost. The first cycle after release arbitrates from channel 0.

## Structure
- Package sma_rr_pkg holds:
  - default CHANNELS and WIDTH;
  - CHAN_W = clog2(CHANNELS);
  - the signed sample typedef;
  - the channel-index typedef.
- Sub-module rr_arbiter(CHANNELS) takes req, enable and ptr. It returns a one-hot grant and an encoded index. It is purely combinational.
- The top level owns:
  - ptr;
  - the history bank, one WIDTH×3 register set per channel, indexed by grant;
  - the shared adder tree (x+h1)+(h2+h3);
  - the output register.

## Test plan
- Single channel 0, y_ready=1, samples 1,2,3,4,5 → y_data 1,3,6,10,14; y_chan=0 every result; one-cycle latency.
- All four channels valid continuously, each sending constant 100·(i+1) → grant order 0,1,2,3,0…; the fourth result from channel 2 is 1200; no gaps.
- Wrap: channel 1 sends 16000 four times → the last sum 64000 wraps to −1536.
- Back-pressure: y_ready=0 for 3 cycles with a result pending → x_ready all 0, y_data stable, ptr frozen. Release → the held result drains and the next grant issues in the same cycle.
- Flush: channel 0 history {5,5,5}, flush together with accept of x=7 → y_data=7. The next sample 1 → y_data=8.
- Async reset asserted mid-burst, between clock edges → y_valid=0 immediately. After release, channel 3 sends 9 → y_data=9.
